// File: rtl/unlock_ctrl.sv
// Unlock controller: gathers KEY_BYTES bytes, asks the comparator, unlocks or counts failures into a lockout.
// Optional inter-byte timeout is built when INTERBYTE_TIMEOUT_EN is defined.
module unlock_ctrl #(
  parameter int KEY_BYTES      = 8,
  parameter int MAX_FAILS      = 3,
  parameter int LOCKOUT_CYCLES = 12000000,
  parameter int TIMEOUT_CYCLES = 120000
) (
  input  logic       clk_12,
  input  logic       rst,
  input  logic       byte_valid,
  input  logic [7:0] byte_data,
  output logic       byte_fwd,
  output logic [7:0] byte_out,
  output logic       sr_clear,
  output logic       cmp_req,
  input  logic       cmp_ack,
  input  logic       cmp_match,
  output logic       unlocked,
  output logic       locked_out,
  output logic [1:0] fail_count
);

  typedef enum logic [1:0] {COLLECT, COMPARE, UNLOCKED, LOCKOUT} state_t;

  localparam int              LT_W       = (LOCKOUT_CYCLES > 1) ? $clog2(LOCKOUT_CYCLES) : 1;
  localparam logic [LT_W-1:0] LT_LOAD    = LT_W'(LOCKOUT_CYCLES - 1);
  localparam logic [3:0]      LAST_IDX   = 4'(KEY_BYTES - 1);
  localparam logic [2:0]      FAIL_LIMIT = 3'(MAX_FAILS);

  generate
    if (KEY_BYTES < 1 || KEY_BYTES > 15 || MAX_FAILS < 1 || MAX_FAILS > 3 ||
        LOCKOUT_CYCLES < 1 || TIMEOUT_CYCLES < 1) begin : g_bad_param
      $error("unlock_ctrl: parameter out of range");
    end
  endgenerate

  state_t          state, state_next;
  logic [3:0]      byte_cnt, byte_cnt_next;
  logic [LT_W-1:0] lock_timer, lock_timer_next;

  logic       byte_fwd_d, sr_clear_d, cmp_req_d, unlocked_d, locked_out_d;
  logic [7:0] byte_out_d;
  logic [1:0] fail_count_d;

  logic       accept, last_byte, ack, pass, fail_hit, lock_now, relock, lock_done, timeout_hit;
  logic [2:0] fail_inc;

  assign accept    = (state == COLLECT) && byte_valid;
  assign last_byte = accept && (byte_cnt == LAST_IDX);
  assign ack       = (state == COMPARE) && cmp_ack;
  assign pass      = ack && cmp_match;
  assign fail_hit  = ack && !cmp_match;
  assign fail_inc  = {1'b0, fail_count} + 3'd1;
  assign lock_now  = fail_hit && (fail_inc >= FAIL_LIMIT);
  assign relock    = (state == UNLOCKED) && byte_valid;
  assign lock_done = (state == LOCKOUT) && (lock_timer == '0);

`ifdef INTERBYTE_TIMEOUT_EN
  localparam int              TO_W    = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);

  logic [TO_W-1:0] idle_cnt, idle_cnt_next;
  logic            idling;

  // A byte arriving in the expiry cycle is not idle, so acceptance beats the timeout.
  assign idling      = (state == COLLECT) && !byte_valid && (byte_cnt != 4'd0);
  assign timeout_hit = idling && (idle_cnt == TO_LAST);

  always_comb begin
    idle_cnt_next = '0;
    if (idling && !timeout_hit)
      idle_cnt_next = idle_cnt + TO_W'(1);
  end

  always_ff @(posedge clk_12) begin
    if (rst)
      idle_cnt <= '0;
    else
      idle_cnt <= idle_cnt_next;
  end
`else
  assign timeout_hit = 1'b0;
`endif

  always_ff @(posedge clk_12) begin
    if (rst) begin
      state      <= COLLECT;
      byte_cnt   <= 4'd0;
      lock_timer <= '0;
      byte_fwd   <= 1'b0;
      byte_out   <= 8'd0;
      sr_clear   <= 1'b0;
      cmp_req    <= 1'b0;
      unlocked   <= 1'b0;
      locked_out <= 1'b0;
      fail_count <= 2'd0;
    end else begin
      state      <= state_next;
      byte_cnt   <= byte_cnt_next;
      lock_timer <= lock_timer_next;
      byte_fwd   <= byte_fwd_d;
      byte_out   <= byte_out_d;
      sr_clear   <= sr_clear_d;
      cmp_req    <= cmp_req_d;
      unlocked   <= unlocked_d;
      locked_out <= locked_out_d;
      fail_count <= fail_count_d;
    end
  end

  always_comb begin
    state_next      = state;
    byte_cnt_next   = byte_cnt;
    lock_timer_next = lock_timer;
    case (state)
      COLLECT: begin
        if (last_byte) begin
          state_next    = COMPARE;
          byte_cnt_next = 4'd0;
        end else if (accept) begin
          byte_cnt_next = byte_cnt + 4'd1;
        end else if (timeout_hit) begin
          byte_cnt_next = 4'd0;
        end
      end
      COMPARE: begin
        if (pass) begin
          state_next = UNLOCKED;
        end else if (lock_now) begin
          state_next      = LOCKOUT;
          lock_timer_next = LT_LOAD;
        end else if (fail_hit) begin
          state_next = COLLECT;
        end
      end
      UNLOCKED: begin
        if (relock) begin
          state_next    = COLLECT;
          byte_cnt_next = 4'd0;
        end
      end
      LOCKOUT: begin
        if (lock_done)
          state_next = COLLECT;
        else
          lock_timer_next = lock_timer - LT_W'(1);
      end
      default: state_next = COLLECT;
    endcase
  end

  // Output values are computed for the next state so every output is a plain register.
  always_comb begin
    byte_fwd_d   = accept;
    byte_out_d   = accept ? byte_data : byte_out;
    sr_clear_d   = fail_hit || relock || timeout_hit;
    cmp_req_d    = (state_next == COMPARE);
    unlocked_d   = (state_next == UNLOCKED);
    locked_out_d = (state_next == LOCKOUT);
    fail_count_d = fail_count;
    if (pass || lock_done)
      fail_count_d = 2'd0;
    else if (lock_now)
      fail_count_d = FAIL_LIMIT[1:0];
    else if (fail_hit)
      fail_count_d = fail_inc[1:0];
  end

endmodule

// File: tb/tb_unlock_ctrl.sv
// Directed testbench for unlock_ctrl: unlock, failures into lockout, relock, partial attempts and reset.
// Timeout expectations follow INTERBYTE_TIMEOUT_EN when it is defined for the build.
module tb_unlock_ctrl;

  logic       clk_12 = 1'b0;
  logic       rst;
  logic       byte_valid;
  logic [7:0] byte_data;
  logic       byte_fwd;
  logic [7:0] byte_out;
  logic       sr_clear;
  logic       cmp_req;
  logic       cmp_ack;
  logic       cmp_match;
  logic       unlocked;
  logic       locked_out;
  logic [1:0] fail_count;

  int vec_count  = 0;
  int miss_count = 0;

  unlock_ctrl #(
    .KEY_BYTES(8), .MAX_FAILS(3), .LOCKOUT_CYCLES(100), .TIMEOUT_CYCLES(50)
  ) dut (
    .clk_12(clk_12), .rst(rst), .byte_valid(byte_valid), .byte_data(byte_data),
    .byte_fwd(byte_fwd), .byte_out(byte_out), .sr_clear(sr_clear), .cmp_req(cmp_req),
    .cmp_ack(cmp_ack), .cmp_match(cmp_match), .unlocked(unlocked),
    .locked_out(locked_out), .fail_count(fail_count)
  );

  always #5 clk_12 = ~clk_12;

  task automatic tick;
    @(posedge clk_12);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vec_count++;
    if (obs !== exp) begin
      miss_count++;
      $display("[TB] FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input logic [7:0] data, input logic expect_fwd);
    byte_valid = 1'b1;
    byte_data  = data;
    tick;
    byte_valid = 1'b0;
    checkOutput("byte_fwd", 32'(byte_fwd), 32'(expect_fwd));
    if (expect_fwd)
      checkOutput("byte_out", 32'(byte_out), 32'(data));
    checkOutput("fwd_clr_excl", 32'(byte_fwd & sr_clear), 32'd0);
  endtask

  task automatic sendBytes(input logic [7:0] base, input int n);
    for (int i = 0; i < n; i++)
      applyStimulus(base + 8'(i), 1'b1);
  endtask

  // Full key: the compare request must appear on the eighth byte and not before.
  task automatic doKey(input logic [7:0] base);
    sendBytes(base, 7);
    checkOutput("cmp_req_early", 32'(cmp_req), 32'd0);
    applyStimulus(base + 8'd7, 1'b1);
    checkOutput("cmp_req_rise", 32'(cmp_req), 32'd1);
  endtask

  task automatic ackCompare(input logic match);
    cmp_ack   = 1'b1;
    cmp_match = match;
    checkOutput("cmp_req_at_ack", 32'(cmp_req), 32'd1);
    tick;
    cmp_ack   = 1'b0;
    cmp_match = 1'b0;
    checkOutput("cmp_req_drop", 32'(cmp_req), 32'd0);
  endtask

  task automatic checkResetOutputs(input string tag);
    checkOutput({tag, "_byte_fwd"},   32'(byte_fwd),   32'd0);
    checkOutput({tag, "_byte_out"},   32'(byte_out),   32'd0);
    checkOutput({tag, "_sr_clear"},   32'(sr_clear),   32'd0);
    checkOutput({tag, "_cmp_req"},    32'(cmp_req),    32'd0);
    checkOutput({tag, "_unlocked"},   32'(unlocked),   32'd0);
    checkOutput({tag, "_locked_out"}, 32'(locked_out), 32'd0);
    checkOutput({tag, "_fail_count"}, 32'(fail_count), 32'd0);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not complete, expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int  cnt;
    logic seen;

    rst        = 1'b1;
    byte_valid = 1'b0;
    byte_data  = 8'd0;
    cmp_ack    = 1'b0;
    cmp_match  = 1'b0;
    tick;
    tick;
    checkResetOutputs("reset");
    rst = 1'b0;

    // A stray ack while collecting must not unlock anything.
    cmp_ack   = 1'b1;
    cmp_match = 1'b1;
    tick;
    cmp_ack   = 1'b0;
    cmp_match = 1'b0;
    checkOutput("stray_ack_unlocked", 32'(unlocked), 32'd0);
    checkOutput("stray_ack_cmp_req", 32'(cmp_req), 32'd0);

    doKey(8'h41);
    tick;
    tick;
    checkOutput("cmp_req_hold", 32'(cmp_req), 32'd1);
    applyStimulus(8'h99, 1'b0);
    ackCompare(1'b1);
    checkOutput("unlock_unlocked", 32'(unlocked), 32'd1);
    checkOutput("unlock_fail_count", 32'(fail_count), 32'd0);
    checkOutput("unlock_sr_clear", 32'(sr_clear), 32'd0);

    applyStimulus(8'h00, 1'b0);
    checkOutput("relock_sr_clear", 32'(sr_clear), 32'd1);
    checkOutput("relock_unlocked", 32'(unlocked), 32'd0);
    tick;
    checkOutput("relock_sr_clear_end", 32'(sr_clear), 32'd0);

    doKey(8'h10);
    applyStimulus(8'hAA, 1'b0);
    ackCompare(1'b0);
    checkOutput("fail1_count", 32'(fail_count), 32'd1);
    checkOutput("fail1_sr_clear", 32'(sr_clear), 32'd1);
    checkOutput("fail1_locked_out", 32'(locked_out), 32'd0);
    doKey(8'h20);
    ackCompare(1'b0);
    checkOutput("fail2_count", 32'(fail_count), 32'd2);
    doKey(8'h30);
    ackCompare(1'b0);
    checkOutput("fail3_count", 32'(fail_count), 32'd3);
    checkOutput("fail3_locked_out", 32'(locked_out), 32'd1);
    checkOutput("fail3_sr_clear", 32'(sr_clear), 32'd1);

    cnt  = 1;
    seen = 1'b0;
    for (int n = 0; n < 300 && locked_out; n++) begin
      byte_valid = (n == 10);
      byte_data  = 8'hEE;
      tick;
      byte_valid = 1'b0;
      seen |= byte_fwd;
      if (locked_out) cnt++;
    end
    checkOutput("lockout_len", 32'(cnt), 32'd100);
    checkOutput("lockout_fwd", 32'(seen), 32'd0);
    checkOutput("lockout_end_locked", 32'(locked_out), 32'd0);
    checkOutput("lockout_end_count", 32'(fail_count), 32'd0);

    doKey(8'h50);
    ackCompare(1'b0);
    checkOutput("refail_count", 32'(fail_count), 32'd1);
    doKey(8'h58);
    ackCompare(1'b1);
    checkOutput("reunlock_count", 32'(fail_count), 32'd0);
    checkOutput("reunlock_unlocked", 32'(unlocked), 32'd1);
    applyStimulus(8'h00, 1'b0);
    tick;

    sendBytes(8'h60, 3);
    seen = 1'b0;
    repeat (49) begin
      tick;
      seen |= sr_clear;
    end
    tick;
    checkOutput("idle_early_clear", 32'(seen), 32'd0);
`ifdef INTERBYTE_TIMEOUT_EN
    checkOutput("timeout_sr_clear", 32'(sr_clear), 32'd1);
    doKey(8'h70);
`else
    checkOutput("persist_sr_clear", 32'(sr_clear), 32'd0);
    sendBytes(8'h63, 4);
    checkOutput("persist_cmp_early", 32'(cmp_req), 32'd0);
    applyStimulus(8'h67, 1'b1);
    checkOutput("persist_cmp_req", 32'(cmp_req), 32'd1);
`endif
    ackCompare(1'b0);
    checkOutput("partial_fail_count", 32'(fail_count), 32'd1);

    sendBytes(8'h80, 3);
    repeat (49) tick;
    applyStimulus(8'h83, 1'b1);
    checkOutput("expiry_sr_clear", 32'(sr_clear), 32'd0);
    sendBytes(8'h84, 3);
    checkOutput("expiry_cmp_early", 32'(cmp_req), 32'd0);
    applyStimulus(8'h87, 1'b1);
    checkOutput("expiry_cmp_req", 32'(cmp_req), 32'd1);
    ackCompare(1'b0);
    checkOutput("expiry_fail_count", 32'(fail_count), 32'd2);

    doKey(8'h90);
    ackCompare(1'b0);
    checkOutput("lock2_locked_out", 32'(locked_out), 32'd1);
    repeat (39) tick;
    checkOutput("lock2_cycle40", 32'(locked_out), 32'd1);
    rst = 1'b1;
    tick;
    rst = 1'b0;
    checkResetOutputs("rst_lockout");
    doKey(8'hA0);
    ackCompare(1'b1);
    checkOutput("post_rst_unlocked", 32'(unlocked), 32'd1);
    checkOutput("post_rst_count", 32'(fail_count), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vec_count, miss_count);
    $finish;
  end

endmodule
